// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage.
// Imported by fetch_unit and next_pc.
package pa_riscv;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_VALID,
    S_FAULT
  } ty_fetchState;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP = 32'h0000_0004;

  function automatic logic is_misaligned(
    input logic [31:0] addr
  );
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Next-PC adder: sequential or branch target.
// Flags targets that are not word aligned.
module next_pc
  import pa_riscv::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_pcSrc,
  input  logic [31:0] i_imm,
  output logic [31:0] o_target,
  output logic        o_misaligned
);

  logic [31:0] offset;

  // Pick the increment, add with natural 32-bit wrap
  always_comb begin
    offset       = i_pcSrc ? i_imm : PC_STEP;
    o_target     = i_pc + offset;
    o_misaligned = is_misaligned(o_target);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC owner, imem req/gnt/rvalid master.
// Holds one instruction until downstream consumes it.
module fetch_unit
  import pa_riscv::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_arst,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemGnt,
  input  logic        i_imemRvalid,
  input  logic [31:0] i_imemRdata,
  input  logic        i_stall,
  input  logic        i_pcSrc,
  input  logic [31:0] i_immediateExtended,
  output logic [31:0] o_instruction,
  output logic        o_instrValid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcPlus4,
  output logic        o_fetchFault
);

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  ty_fetchState state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         req_q;
  logic         valid_q;
  logic         fault_q;

  logic [31:0]  target;
  logic         misaligned;

  next_pc u_next_pc (
    .i_pc         (pc_q),
    .i_pcSrc      (i_pcSrc),
    .i_imm        (i_immediateExtended),
    .o_target     (target),
    .o_misaligned (misaligned)
  );

  // Fetch FSM with registered handshake and status outputs
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= S_IDLE;
      pc_q    <= PC_INIT;
      instr_q <= NOP;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          if (i_imemGnt) begin
            state_q <= S_WAIT;
            req_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (i_imemRvalid) begin
            instr_q <= i_imemRdata;
            valid_q <= 1'b1;
            state_q <= S_VALID;
          end
        end
        S_VALID: begin
          if (!i_stall) begin
            valid_q <= 1'b0;
            if (misaligned) begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end else begin
              pc_q    <= target;
              req_q   <= 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        S_FAULT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          fault_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Output wiring; address and PC both track the held PC
  always_comb begin
    o_imemReq     = req_q;
    o_imemAddr    = pc_q;
    o_instruction = instr_q;
    o_instrValid  = valid_q;
    o_pc          = pc_q;
    o_pcPlus4     = pc_q + PC_STEP;
    o_fetchFault  = fault_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit.
// Inputs change and outputs are sampled on the falling edge.
module tb_fetch_unit;

  localparam logic [31:0] TAG = 32'hC0DE_0000;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        arst;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        stall;
  logic        pc_src;
  logic [31:0] imm;
  logic [31:0] instr;
  logic        ivalid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        fault;

  logic        force_rd;
  logic [31:0] forced;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rdata = force_rd ? forced : (addr ^ TAG);

  fetch_unit dut (
    .i_clk               (clk),
    .i_arst              (arst),
    .o_imemReq           (req),
    .o_imemAddr          (addr),
    .i_imemGnt           (gnt),
    .i_imemRvalid        (rvalid),
    .i_imemRdata         (rdata),
    .i_stall             (stall),
    .i_pcSrc             (pc_src),
    .i_immediateExtended (imm),
    .o_instruction       (instr),
    .o_instrValid        (ivalid),
    .o_pc                (pc),
    .o_pcPlus4           (pc4),
    .o_fetchFault        (fault)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {31'b0, req}, 32'd0);
    chk({tag, "_val"}, {31'b0, ivalid}, 32'd0);
    chk({tag, "_flt"}, {31'b0, fault}, 32'd0);
    chk({tag, "_ins"}, instr, NOPW);
    chk({tag, "_pc"}, pc, 32'h0);
  endtask

  // Walk a FETCH/WAIT/VALID round with gnt and rvalid high
  task automatic round(
    input string       tag,
    input logic [31:0] exp_pc
  );
    chk({tag, "_req"}, {31'b0, req}, 32'd1);
    chk({tag, "_adr"}, addr, exp_pc);
    @(negedge clk);
    chk({tag, "_wreq"}, {31'b0, req}, 32'd0);
    @(negedge clk);
    chk({tag, "_val"}, {31'b0, ivalid}, 32'd1);
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_ins"}, instr, exp_pc ^ TAG);
  endtask

  initial begin
    arst     = 1'b1;
    gnt      = 1'b1;
    rvalid   = 1'b1;
    stall    = 1'b0;
    pc_src   = 1'b0;
    imm      = 32'h0;
    force_rd = 1'b0;
    forced   = 32'h0;

    // 1: reset values, then release
    @(negedge clk);
    @(negedge clk);
    chk_reset("rst");
    arst = 1'b0;
    @(negedge clk);
    round("t1", 32'h0);
    chk("t1_pc4", pc4, 32'h4);

    // 2: sequential fetch 4, 8, C
    @(negedge clk);
    round("t2a", 32'h4);
    @(negedge clk);
    round("t2b", 32'h8);
    stall = 1'b1;
    @(negedge clk);
    chk("t2_hold", {31'b0, ivalid}, 32'd1);
    stall = 1'b0;
    @(negedge clk);
    round("t2c", 32'hC);

    // 3: stall 5 cycles with toggling branch inputs
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc_src = i[0];
      imm    = 32'h1000 + 32'(i) * 32'h10;
      @(negedge clk);
      chk("t3_val", {31'b0, ivalid}, 32'd1);
      chk("t3_req", {31'b0, req}, 32'd0);
      chk("t3_pc", pc, 32'hC);
      chk("t3_ins", instr, 32'hC ^ TAG);
    end
    stall  = 1'b0;
    pc_src = 1'b1;
    imm    = 32'h34;
    @(negedge clk);
    pc_src = 1'b0;
    imm    = 32'h0;

    // 4: branches back and forward
    round("t4a", 32'h40);
    pc_src = 1'b1;
    imm    = 32'hFFFF_FFF8;
    @(negedge clk);
    round("t4b", 32'h38);
    imm = 32'h108;
    @(negedge clk);
    round("t4c", 32'h140);

    // PC wrap at top of address space
    imm = 32'hFFFF_FEBC;
    @(negedge clk);
    round("wr_a", 32'hFFFF_FFFC);
    chk("wr_pc4", pc4, 32'h0);
    pc_src = 1'b0;
    @(negedge clk);
    chk("wr_flt", {31'b0, fault}, 32'd0);
    round("wr_b", 32'h0);
    pc_src = 1'b1;
    imm    = 32'h10;
    @(negedge clk);
    round("t5a", 32'h10);

    // 5: misaligned target faults and stops
    imm = 32'h6;
    @(negedge clk);
    pc_src = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_flt", {31'b0, fault}, 32'd1);
      chk("t5_req", {31'b0, req}, 32'd0);
      chk("t5_val", {31'b0, ivalid}, 32'd0);
      @(negedge clk);
    end

    // 6: reset, delayed gnt/rvalid, stray rvalid
    arst = 1'b1;
    #1;
    chk_reset("t6r");
    gnt    = 1'b0;
    rvalid = 1'b0;
    stall  = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    force_rd = 1'b1;
    forced   = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_req", {31'b0, req}, 32'd1);
      chk("t6_adr", addr, 32'h0);
      chk("t6_ins", instr, NOPW);
      rvalid = (i == 1);
      @(negedge clk);
    end
    rvalid   = 1'b0;
    force_rd = 1'b0;
    chk("t6_req3", {31'b0, req}, 32'd1);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_wreq", {31'b0, req}, 32'd0);
      chk("t6_wval", {31'b0, ivalid}, 32'd0);
      @(negedge clk);
    end
    rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    chk("t6_val", {31'b0, ivalid}, 32'd1);
    chk("t6_ins2", instr, TAG);
    stall = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    chk("t6_adr4", addr, 32'h4);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    chk("t6_wait", {31'b0, req}, 32'd0);
    arst = 1'b1;
    #1;
    chk_reset("t6w");
    @(negedge clk);
    arst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
